pwm_duty_sequencer: RTL and testbench

Sits between the PS/2 scancode receiver and the PWM generator. It decodes scancode byte streams, handling F0 break and E0 extended prefixes, into a target duty value. It then ramps the live duty toward that target in fixed steps, updating only at PWM period boundaries, so the output never glitches mid-period. The PWM generator consumes `duty` directly as its compare threshold.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/ps2_key_decoder.sv | 87 ++++++++
 rtl/pwm_duty_sequencer.sv | 80 ++++++++
 tb/tb_pwm_duty_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PS/2-driven PWM duty sequencer.
// Scancodes, duty presets and the prefix decoder state enum.
package pwm_pkg;

  localparam logic [7:0] KEY_F        = 8'h2B;
  localparam logic [7:0] KEY_Q        = 8'h15;
  localparam logic [7:0] KEY_H        = 8'h33;
  localparam logic [7:0] KEY_X        = 8'h22;
  localparam logic [7:0] KEY_SPACE    = 8'h29;
  localparam logic [7:0] KEY_KP_PLUS  = 8'h79;
  localparam logic [7:0] KEY_KP_MINUS = 8'h7B;
  localparam logic [7:0] PFX_BRK      = 8'hF0;
  localparam logic [7:0] PFX_EXT      = 8'hE0;

  localparam int unsigned DUTY_F = 41;
  localparam int unsigned DUTY_Q = 51;
  localparam int unsigned DUTY_H = 61;
  localparam int unsigned DUTY_X = 81;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } dec_state_e;

endpackage

// File: rtl/ps2_key_decoder.sv
// PS/2 prefix FSM (F0 break / E0 extended) and make-code map.
// Produces the registered target duty and a one-cycle key_err pulse.
module ps2_key_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W    = 10,
  parameter int unsigned MAX_DUTY  = 800,
  parameter int unsigned FINE_STEP = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [7:0]        scancode,
  output logic [DUTY_W-1:0] target,
  output logic              key_err
);

  localparam logic [DUTY_W-1:0] MAX_W  = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W:0]   MAX_W1 = (DUTY_W+1)'(MAX_DUTY);
  localparam logic [DUTY_W:0]   FS_W1  = (DUTY_W+1)'(FINE_STEP);
  localparam logic [DUTY_W-1:0] FS_W   = DUTY_W'(FINE_STEP);
  localparam logic [DUTY_W-1:0] P_F = DUTY_W'((DUTY_F > MAX_DUTY) ? MAX_DUTY : DUTY_F);
  localparam logic [DUTY_W-1:0] P_Q = DUTY_W'((DUTY_Q > MAX_DUTY) ? MAX_DUTY : DUTY_Q);
  localparam logic [DUTY_W-1:0] P_H = DUTY_W'((DUTY_H > MAX_DUTY) ? MAX_DUTY : DUTY_H);
  localparam logic [DUTY_W-1:0] P_X = DUTY_W'((DUTY_X > MAX_DUTY) ? MAX_DUTY : DUTY_X);

  dec_state_e        state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              key_err_q, key_err_d;
  logic [DUTY_W:0]   sum_up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      key_err_q <= key_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    key_err_d = 1'b0;
    // Extra bit so the saturating add cannot wrap before the clamp.
    sum_up    = {1'b0, target_q} + FS_W1;
    if (code_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (scancode == PFX_BRK) begin
            state_d = S_BRK;
          end else if (scancode == PFX_EXT) begin
            state_d = S_EXT;
          end else begin
            case (scancode)
              KEY_F:        target_d = P_F;
              KEY_Q:        target_d = P_Q;
              KEY_H:        target_d = P_H;
              KEY_X:        target_d = P_X;
              KEY_SPACE:    target_d = '0;
              KEY_KP_PLUS:  target_d = (sum_up > MAX_W1) ? MAX_W : sum_up[DUTY_W-1:0];
              KEY_KP_MINUS: target_d = (target_q >= FS_W) ? (target_q - FS_W) : '0;
              default:      key_err_d = 1'b1;
            endcase
          end
        end
        S_BRK: begin
          if (scancode != PFX_BRK) state_d = S_IDLE;
        end
        S_EXT: begin
          state_d = (scancode == PFX_BRK) ? S_EXT_BRK : S_IDLE;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign target  = target_q;
  assign key_err = key_err_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the live PWM duty toward the decoded target, stepping only at
// PWM period boundaries so the compare threshold never changes mid-period.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned MAX_DUTY     = 800,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RAMP_PERIODS = 4,
  parameter int unsigned FINE_STEP    = 10
) (
  input  logic              clkdiv4,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [7:0]        scancode,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              key_err
);

  localparam int unsigned       CNT_W    = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RAMP_PERIODS - 1);
  localparam logic [DUTY_W-1:0] STEP_W   = DUTY_W'(STEP);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DUTY_W-1:0] target_w;
  logic [DUTY_W-1:0] diff_up, diff_dn;

  ps2_key_decoder #(
    .DUTY_W    (DUTY_W),
    .MAX_DUTY  (MAX_DUTY),
    .FINE_STEP (FINE_STEP)
  ) u_dec (
    .clk        (clkdiv4),
    .rst        (reset),
    .code_valid (code_valid),
    .scancode   (scancode),
    .target     (target_w),
    .key_err    (key_err)
  );

  always_ff @(posedge clkdiv4 or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      cnt_q  <= '0;
    end else begin
      duty_q <= duty_d;
      cnt_q  <= cnt_d;
    end
  end

  // target_w is the registered (pre-edge) target, so a same-edge keypress
  // only affects the following step.
  always_comb begin
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    diff_up = target_w - duty_q;
    diff_dn = duty_q - target_w;
    if (period_end) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (duty_q < target_w) begin
          duty_d = duty_q + ((diff_up < STEP_W) ? diff_up : STEP_W);
        end else if (duty_q > target_w) begin
          duty_d = duty_q - ((diff_dn < STEP_W) ? diff_dn : STEP_W);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign duty   = duty_q;
  assign target = target_w;
  assign busy   = (duty_q != target_w);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed + randomized bench for pwm_duty_sequencer with a behavioural
// reference model of the key map and ramp rules.
module tb_pwm_duty_sequencer;

  localparam int DUTY_W       = 10;
  localparam int MAX_DUTY     = 800;
  localparam int STEP         = 1;
  localparam int RAMP_PERIODS = 4;
  localparam int FINE_STEP    = 10;

  logic              clkdiv4 = 1'b0;
  logic              reset = 1'b0;
  logic              code_valid = 1'b0;
  logic [7:0]        scancode = 8'h00;
  logic              period_end = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic [DUTY_W-1:0] target;
  logic              busy;
  logic              key_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_duty, m_target, m_cnt, m_kerr;
  bit m_brk, m_ext;

  pwm_duty_sequencer #(
    .DUTY_W       (DUTY_W),
    .MAX_DUTY     (MAX_DUTY),
    .STEP         (STEP),
    .RAMP_PERIODS (RAMP_PERIODS),
    .FINE_STEP    (FINE_STEP)
  ) dut (
    .clkdiv4    (clkdiv4),
    .reset      (reset),
    .code_valid (code_valid),
    .scancode   (scancode),
    .period_end (period_end),
    .duty       (duty),
    .target     (target),
    .busy       (busy),
    .key_err    (key_err)
  );

  always #5 clkdiv4 = ~clkdiv4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_target = 0; m_cnt = 0; m_kerr = 0;
    m_brk = 0; m_ext = 0;
  endtask

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input bit cv, input int b, input bit pe);
    int old_t;
    old_t  = m_target;
    m_kerr = 0;
    if (pe) begin
      if (m_cnt == RAMP_PERIODS - 1) begin
        m_cnt = 0;
        if (m_duty < old_t)      m_duty = m_duty + min_i(STEP, old_t - m_duty);
        else if (m_duty > old_t) m_duty = m_duty - min_i(STEP, m_duty - old_t);
      end else begin
        m_cnt++;
      end
    end
    if (cv) begin
      if (m_brk && m_ext) begin
        m_brk = 0; m_ext = 0;
      end else if (m_brk) begin
        if (b != 'hF0) m_brk = 0;
      end else if (m_ext) begin
        if (b == 'hF0) m_brk = 1; else m_ext = 0;
      end else if (b == 'hF0) begin
        m_brk = 1;
      end else if (b == 'hE0) begin
        m_ext = 1;
      end else begin
        case (b)
          'h2B: m_target = min_i(41, MAX_DUTY);
          'h15: m_target = min_i(51, MAX_DUTY);
          'h33: m_target = min_i(61, MAX_DUTY);
          'h22: m_target = min_i(81, MAX_DUTY);
          'h29: m_target = 0;
          'h79: m_target = min_i(m_target + FINE_STEP, MAX_DUTY);
          'h7B: m_target = (m_target - FINE_STEP < 0) ? 0 : m_target - FINE_STEP;
          default: m_kerr = 1;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".duty"},    32'(duty),    32'(m_duty));
    chk({tag, ".target"},  32'(target),  32'(m_target));
    chk({tag, ".busy"},    32'(busy),    32'(m_duty != m_target));
    chk({tag, ".key_err"}, 32'(key_err), 32'(m_kerr));
  endtask

  // Called at a negedge; drives one cycle, checks #1 after the posedge.
  task automatic step(input string tag, input bit cv, input logic [7:0] sc, input bit pe);
    code_valid = cv; scancode = sc; period_end = pe;
    @(posedge clkdiv4);
    model_edge(cv, int'(sc), pe);
    #1;
    code_valid = 1'b0; scancode = 8'h00; period_end = 1'b0;
    check_all(tag);
    @(negedge clkdiv4);
  endtask

  logic [7:0] pool [12] = '{8'h2B, 8'h15, 8'h33, 8'h22, 8'h29, 8'h79,
                            8'h7B, 8'hF0, 8'hE0, 8'h1C, 8'h79, 8'h7B};

  initial begin
    int guard;
    logic [7:0] b;
    model_reset();

    // async reset mid-clock
    #2 reset = 1'b1;
    #1 check_all("reset");
    @(negedge clkdiv4);
    reset = 1'b0;

    step("make_2B", 1, 8'h2B, 0);
    chk("make_2B.target_41", 32'(target), 32'd41);
    for (int i = 0; i < 20; i++) step("ramp20", 0, 8'h00, 1);
    chk("ramp20.duty_5", 32'(duty), 32'd5);

    step("brk_F0", 1, 8'hF0, 0);
    step("brk_2B", 1, 8'h2B, 0);
    step("ext_E0", 1, 8'hE0, 0);
    step("ext_F0", 1, 8'hF0, 0);
    step("ext_15", 1, 8'h15, 0);
    chk("ext.target_41", 32'(target), 32'd41);
    step("after_ext_make", 1, 8'h15, 0);
    step("restore_2B", 1, 8'h2B, 0);

    step("unmapped_1C", 1, 8'h1C, 0);
    chk("unmapped.key_err_hi", 32'(key_err), 32'd1);
    step("unmapped_next", 0, 8'h00, 0);
    chk("unmapped.key_err_lo", 32'(key_err), 32'd0);

    guard = 0;
    while (!(m_duty == 40 && m_cnt == RAMP_PERIODS - 1) && guard < 1000) begin
      step("ramp_to_40", 0, 8'h00, 1);
      guard++;
    end
    chk("ramp_to_40.reached", 32'(guard < 1000), 32'd1);
    step("same_edge_33", 1, 8'h33, 1);
    chk("same_edge.duty_41", 32'(duty), 32'd41);
    chk("same_edge.target_61", 32'(target), 32'd61);
    chk("same_edge.busy", 32'(busy), 32'd1);

    step("space", 1, 8'h29, 0);
    for (int i = 0; i < 81; i++) step("kp_plus", 1, 8'h79, 0);
    chk("kp_plus.sat_800", 32'(target), 32'd800);
    step("set_41", 1, 8'h2B, 0);
    for (int i = 0; i < 5; i++) step("kp_minus", 1, 8'h7B, 0);
    chk("kp_minus.floor_0", 32'(target), 32'd0);

    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      step("random", 1'($urandom_range(0, 1)), b, ($urandom_range(0, 2) == 0));
    end

    // reset mid-ramp and mid-prefix
    step("pre_rst_22", 1, 8'h22, 0);
    for (int i = 0; i < 6; i++) step("pre_rst_ramp", 0, 8'h00, 1);
    step("pre_rst_F0", 1, 8'hF0, 0);
    #3 reset = 1'b1;
    model_reset();
    #1 check_all("reset_mid");
    @(negedge clkdiv4);
    reset = 1'b0;
    step("post_rst_2B", 1, 8'h2B, 0);
    chk("post_rst.target_41", 32'(target), 32'd41);
    for (int i = 0; i < 8; i++) step("post_rst_ramp", 0, 8'h00, 1);
    chk("post_rst.duty_2", 32'(duty), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
